wb_arbiter_rr: RTL and testbench

//  N-master to 1-slave Wishbone classic arbiter with fair round-robin grant.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_rr_picker.sv | 36 +++
 rtl/wb_arbiter_rr.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter and its picker.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int WDOG_W = 16;

    // Width needed to index n masters; never less than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping at N-1.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = owner_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [OW-1:0] last_i,
    output logic          valid_o,
    output logic [OW-1:0] idx_o
);

    int            sum;
    logic [OW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        cand    = '0;
        // Offsets 1..N visit every master once, last_i itself coming last.
        for (int k = 1; k <= N; k++) begin
            sum = int'(last_i) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = OW'(sum);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave Wishbone classic arbiter, round-robin grant held for a whole cyc.
// Optional watchdog built when WB_ARB_TIMEOUT_EN is defined; otherwise m_err_o is tied low.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_int_o,
    output logic                              s_we_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_int_i,
    output logic [NUM_MASTERS-1:0]            gnt_o,
    output arb_state_e                        state_o
);

    localparam int OW = owner_w(NUM_MASTERS);

    arb_state_e             state_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          last_q;
    logic [NUM_MASTERS-1:0] gnt_q;

    logic                   pick_valid;
    logic [OW-1:0]          pick_idx;
    logic                   timeout;

    wb_rr_picker #(
        .N  (NUM_MASTERS),
        .OW (OW)
    ) u_picker (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Slave-side mux and owner-only return path; everything is zero while IDLE.
    always_comb begin
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_dat_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (state_q == ARB_OWNED && owner_q == OW'(k)) begin
                s_we_o  = m_we_i[k];
                s_cyc_o = m_cyc_i[k];
                s_stb_o = m_stb_i[k];
                s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
                s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                m_ack_o[k] = s_ack_i & m_stb_i[k];
                m_dat_o[k*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
            end
        end
    end

    assign m_int_o = {NUM_MASTERS{s_int_i}};
    assign gnt_o   = gnt_q;
    assign state_o = state_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;

    // Idle clears the count, so every grant starts from zero; an ack in the limit cycle wins.
    always_comb begin
        timeout = (state_q == ARB_OWNED) && s_stb_o && !s_ack_i && (wdog_q == WDOG_LIMIT);
        wdog_d  = wdog_q;
        if (state_q == ARB_IDLE || s_ack_i) begin
            wdog_d = '0;
        end else if (s_stb_o) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign m_err_o = timeout ? gnt_q : '0;
`else
    assign timeout = 1'b0;
    assign m_err_o = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);
            gnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ARB_OWNED;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        gnt_q   <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                ARB_OWNED: begin
                    // s_cyc_o is the owner's cyc; last_q already holds the owner.
                    if (!s_cyc_o || timeout) begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: grant order, burst atomicity, reset, interrupt, watchdog.
module tb_wb_arbiter_rr;
    import wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [N*SW-1:0] m_sel_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*DW-1:0] m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_int_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_int_i;
    logic [N-1:0]    gnt_o;
    arb_state_e      state_o;

    int           n_cmp = 0;
    int           n_mis = 0;
    logic [N-1:0] exp_q[$];

    wb_arbiter_rr #(
        .NUM_MASTERS    (N),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SEL_WIDTH      (SW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_sel_i (m_sel_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_int_o (m_int_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_int_i (s_int_i),
        .gnt_o   (gnt_o),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        s_ack_i = 1'b1;
        tick();
        tick();
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL rst_gnt: got %b want 0000", gnt_o); end
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_mis++; $display("FAIL rst_s_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_adr_o !== 32'h0) begin n_mis++; $display("FAIL rst_s_adr: got %h want 0", s_adr_o); end
        n_cmp++; if (m_ack_o !== 4'b0000) begin n_mis++; $display("FAIL rst_ack: got %b want 0000", m_ack_o); end
        n_cmp++; if (m_err_o !== 4'b0000) begin n_mis++; $display("FAIL rst_err: got %b want 0000", m_err_o); end
        n_cmp++; if (m_dat_o !== 128'h0) begin n_mis++; $display("FAIL rst_dat: got %h want 0", m_dat_o); end
        n_cmp++; if (state_o !== ARB_IDLE) begin n_mis++; $display("FAIL rst_state: got %0d want 0", state_o); end
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        rst     = 1'b0;
        tick();
    endtask

    task automatic test_single();
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_mis++; $display("FAIL single_latency: got %b want 0", s_cyc_o); end
        tick();
        n_cmp++; if (s_cyc_o !== 1'b1) begin n_mis++; $display("FAIL single_s_cyc: got %b want 1", s_cyc_o); end
        n_cmp++; if (gnt_o !== 4'b0001) begin n_mis++; $display("FAIL single_gnt: got %b want 0001", gnt_o); end
        n_cmp++; if (state_o !== ARB_OWNED) begin n_mis++; $display("FAIL single_state: got %0d want 1", state_o); end
        n_cmp++; if (s_adr_o !== 32'h1000_0000) begin n_mis++; $display("FAIL single_adr: got %h want 10000000", s_adr_o); end
        n_cmp++; if (s_dat_o !== 32'hD000_0000) begin n_mis++; $display("FAIL single_wdat: got %h want d0000000", s_dat_o); end
        n_cmp++; if (s_we_o !== 1'b0) begin n_mis++; $display("FAIL single_we: got %b want 0", s_we_o); end
        n_cmp++; if (m_ack_o !== 4'b0000) begin n_mis++; $display("FAIL single_noack: got %b want 0000", m_ack_o); end
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_0001;
        #1;
        n_cmp++; if (m_ack_o !== 4'b0001) begin n_mis++; $display("FAIL single_ack: got %b want 0001", m_ack_o); end
        n_cmp++; if (m_dat_o !== {96'h0, 32'hCAFE_0001}) begin n_mis++; $display("FAIL single_rdat: got %h want cafe0001 in lane 0", m_dat_o); end
        tick();
        s_ack_i = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        #1;
        n_cmp++; if (gnt_o !== 4'b0001) begin n_mis++; $display("FAIL single_hold: got %b want 0001", gnt_o); end
        tick();
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL single_release: got %b want 0000", gnt_o); end
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_mis++; $display("FAIL single_s_cyc_off: got %b want 0", s_cyc_o); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tick();
            n_cmp++; if (gnt_o !== exp) begin n_mis++; $display("FAIL rr_gnt: got %b want %b", gnt_o, exp); end
            s_ack_i = 1'b1;
            #1;
            n_cmp++; if (m_ack_o !== exp) begin n_mis++; $display("FAIL rr_ack: got %b want %b", m_ack_o, exp); end
            tick();
            s_ack_i = 1'b0;
            m_cyc_i = m_cyc_i & ~exp;
            m_stb_i = m_stb_i & ~exp;
            tick();
            n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL rr_idle_gap: got %b want 0000", gnt_o); end
            m_cyc_i = m_cyc_i | exp;
            m_stb_i = m_stb_i | exp;
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();
    endtask

    task automatic test_burst();
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        tick();
        n_cmp++; if (gnt_o !== 4'b0010) begin n_mis++; $display("FAIL burst_gnt: got %b want 0010", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h1000_0100) begin n_mis++; $display("FAIL burst_adr: got %h want 10000100", s_adr_o); end
        n_cmp++; if (s_we_o !== 1'b1) begin n_mis++; $display("FAIL burst_we: got %b want 1", s_we_o); end
        m_cyc_i = 4'b0110;
        m_stb_i = 4'b0110;
        for (int b = 0; b < 4; b++) begin
            s_ack_i = 1'b1;
            s_dat_i = 32'hB0B0_0000 + 32'(b);
            #1;
            n_cmp++; if (m_ack_o !== 4'b0010) begin n_mis++; $display("FAIL burst_ack%0d: got %b want 0010", b, m_ack_o); end
            n_cmp++; if (m_dat_o !== {64'h0, 32'hB0B0_0000 + 32'(b), 32'h0}) begin n_mis++; $display("FAIL burst_rdat%0d: got %h want lane 1 only", b, m_dat_o); end
            tick();
        end
        m_stb_i = 4'b0100;
        #1;
        n_cmp++; if (m_ack_o !== 4'b0000) begin n_mis++; $display("FAIL stray_ack: got %b want 0000", m_ack_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_mis++; $display("FAIL stb_drop: got %b want 0", s_stb_o); end
        n_cmp++; if (gnt_o !== 4'b0010) begin n_mis++; $display("FAIL stb_drop_hold: got %b want 0010", gnt_o); end
        tick();
        s_ack_i = 1'b0;
        m_cyc_i = 4'b0100;
        tick();
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL burst_idle: got %b want 0000", gnt_o); end
        tick();
        n_cmp++; if (gnt_o !== 4'b0100) begin n_mis++; $display("FAIL burst_next: got %b want 0100", gnt_o); end
        n_cmp++; if (s_adr_o !== 32'h1000_0200) begin n_mis++; $display("FAIL burst_next_adr: got %h want 10000200", s_adr_o); end
    endtask

    task automatic test_reset_mid_burst();
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234_5678;
        #1;
        n_cmp++; if (m_ack_o !== 4'b0100) begin n_mis++; $display("FAIL mid_ack: got %b want 0100", m_ack_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt_o); end
        n_cmp++; if (m_ack_o !== 4'b0000) begin n_mis++; $display("FAIL mid_rst_ack: got %b want 0000", m_ack_o); end
        n_cmp++; if (m_dat_o !== 128'h0) begin n_mis++; $display("FAIL mid_rst_dat: got %h want 0", m_dat_o); end
        tick();
        rst     = 1'b0;
        s_ack_i = 1'b0;
        tick();
        n_cmp++; if (gnt_o !== 4'b0001) begin n_mis++; $display("FAIL mid_rst_m0: got %b want 0001", gnt_o); end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();
    endtask

    task automatic test_interrupt();
        s_int_i = 1'b1;
        #1;
        n_cmp++; if (m_int_o !== 4'b1111) begin n_mis++; $display("FAIL int_on: got %b want 1111", m_int_o); end
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL int_idle: got %b want 0000", gnt_o); end
        s_int_i = 1'b0;
        #1;
        n_cmp++; if (m_int_o !== 4'b0000) begin n_mis++; $display("FAIL int_off: got %b want 0000", m_int_o); end
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_cyc_i = 4'b1000;
        m_stb_i = 4'b1000;
        tick();
        n_cmp++; if (gnt_o !== 4'b1000) begin n_mis++; $display("FAIL to_gnt: got %b want 1000", gnt_o); end
        for (int c = 1; c < 16; c++) begin
            n_cmp++; if (m_err_o !== 4'b0000) begin n_mis++; $display("FAIL to_early%0d: got %b want 0000", c, m_err_o); end
            tick();
        end
        n_cmp++; if (m_err_o !== 4'b1000) begin n_mis++; $display("FAIL to_err: got %b want 1000", m_err_o); end
        n_cmp++; if (s_cyc_o !== 1'b1) begin n_mis++; $display("FAIL to_cyc_last: got %b want 1", s_cyc_o); end
        tick();
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_mis++; $display("FAIL to_cyc_drop: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_mis++; $display("FAIL to_stb_drop: got %b want 0", s_stb_o); end
        n_cmp++; if (gnt_o !== 4'b0000) begin n_mis++; $display("FAIL to_idle: got %b want 0000", gnt_o); end
        n_cmp++; if (m_err_o !== 4'b0000) begin n_mis++; $display("FAIL to_err_pulse: got %b want 0000", m_err_o); end
        tick();
        n_cmp++; if (gnt_o !== 4'b1000) begin n_mis++; $display("FAIL to_regrant: got %b want 1000", gnt_o); end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        m_cyc_i = 4'b1000;
        m_stb_i = 4'b1000;
        tick();
        for (int c = 1; c <= 24; c++) begin
            n_cmp++; if (m_err_o !== 4'b0000) begin n_mis++; $display("FAIL no_to_err%0d: got %b want 0000", c, m_err_o); end
            tick();
        end
        n_cmp++; if (gnt_o !== 4'b1000) begin n_mis++; $display("FAIL no_to_hold: got %b want 1000", gnt_o); end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        m_we_i  = 4'b1010;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_sel_i = {N*SW{1'b1}};
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_int_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_adr_i[k*AW +: AW] = 32'h1000_0000 + 32'(k) * 32'h100;
            m_dat_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_reset_mid_burst();
        test_interrupt();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
